// File: rtl/seq_normalizer.sv
// seq_normalizer: multi-cycle left-normalizer / leading-zero counter.
// One binary-weighted shift stage per clock (WIDTH/2 .. 1), then a settle
// cycle that copies the finished word into the held output registers, then
// a one-cycle DONE pulse. A start in the DONE cycle is accepted.
module seq_normalizer #(
    parameter int WIDTH = 8,
    parameter int LOG2W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [LOG2W-1:0] cnt,
    output logic             zero
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STG    = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] work_reg, work_next;
    logic [LOG2W-1:0] cnt_work_reg, cnt_work_next;
    logic             zero_work_reg, zero_work_next;
    logic [LOG2W-1:0] k_reg, k_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic [LOG2W-1:0] cnt_reg, cnt_next;
    logic             zero_reg, zero_next;

    // Candidate result of every stage; the active stage is picked by k_reg.
    logic [WIDTH-1:0] stage_shift [LOG2W];
    logic [LOG2W-1:0] stage_empty;

    genvar gi;
    generate
        for (gi = 0; gi < LOG2W; gi++) begin : g_stage
            localparam int N = 1 << gi;
            assign stage_shift[gi] = work_reg << N;
            assign stage_empty[gi] = (work_reg[WIDTH-1 -: N] == '0);
        end
    endgenerate

    logic [WIDTH-1:0] sel_shift;
    logic             sel_empty;

    // Select the shift candidate belonging to the current stage index.
    always_comb begin
        sel_shift = work_reg;
        sel_empty = 1'b0;
        for (int i = 0; i < LOG2W; i++) begin
            if (k_reg == LOG2W'(i)) begin
                sel_shift = stage_shift[i];
                sel_empty = stage_empty[i];
            end
        end
    end

    // Next-state and datapath update for the normalizer FSM.
    always_comb begin
        state_next     = state_reg;
        work_next      = work_reg;
        cnt_work_next  = cnt_work_reg;
        zero_work_next = zero_work_reg;
        k_next         = k_reg;
        out_next       = out_reg;
        cnt_next       = cnt_reg;
        zero_next      = zero_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    work_next      = in;
                    cnt_work_next  = '0;
                    zero_work_next = (in == '0);
                    k_next         = LOG2W'(LOG2W - 1);
                    state_next     = S_STG;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_STG: begin
                // Shift only while the top 2**k bits are clear; an all-zero
                // operand never shifts so its count stays 0.
                if (sel_empty && !zero_work_reg) begin
                    work_next     = sel_shift;
                    cnt_work_next = cnt_work_reg | (LOG2W'(1) << k_reg);
                end
                if (k_reg == '0) begin
                    state_next = S_SETTLE;
                end else begin
                    k_next = k_reg - LOG2W'(1);
                end
            end
            S_SETTLE: begin
                // Results reach the outputs exactly when DONE is entered.
                out_next   = work_reg;
                cnt_next   = cnt_work_reg;
                zero_next  = zero_work_reg;
                state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            work_reg      <= '0;
            cnt_work_reg  <= '0;
            zero_work_reg <= 1'b0;
            k_reg         <= '0;
            out_reg       <= '0;
            cnt_reg       <= '0;
            zero_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            work_reg      <= work_next;
            cnt_work_reg  <= cnt_work_next;
            zero_work_reg <= zero_work_next;
            k_reg         <= k_next;
            out_reg       <= out_next;
            cnt_reg       <= cnt_next;
            zero_reg      <= zero_next;
        end
    end

    assign busy = (state_reg == S_STG) || (state_reg == S_SETTLE);
    assign done = (state_reg == S_DONE);
    assign out  = out_reg;
    assign cnt  = cnt_reg;
    assign zero = zero_reg;

endmodule

// File: tb/tb_seq_normalizer.sv
// Directed plus randomized bench for seq_normalizer with a leading-zero
// reference model and a right-shift round-trip check.
module tb_seq_normalizer;

    localparam int WIDTH = 8;
    localparam int LOG2W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;
    logic [LOG2W-1:0] cnt;
    logic             zero;

    int n_vec = 0;
    int n_err = 0;

    seq_normalizer #(.WIDTH(WIDTH), .LOG2W(LOG2W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in    (din),
        .busy  (busy),
        .done  (done),
        .out   (dout),
        .cnt   (cnt),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leading-zero count scanned from the MSB down.
    function automatic int ref_lzc(input logic [WIDTH-1:0] v);
        int  c = 0;
        bit  seen = 0;
        for (int b = WIDTH - 1; b >= 0; b--) begin
            if (v[b]) seen = 1;
            else if (!seen) c++;
        end
        return (v == 0) ? 0 : c;
    endfunction

    // One full operation: pulse start, check busy for the fixed latency,
    // check the DONE cycle against the model, then one idle cycle.
    task automatic run_op(input logic [WIDTH-1:0] v);
        int               exp_cnt;
        logic [WIDTH-1:0] exp_out;
        logic [WIDTH-1:0] prev_out;
        exp_cnt  = ref_lzc(v);
        exp_out  = v << exp_cnt;
        prev_out = dout;
        start = 1'b1;
        din   = v;
        tick();
        start = 1'b0;
        din   = WIDTH'($urandom);
        for (int i = 0; i < 4; i++) begin
            check("busy_inflight", {31'd0, busy}, 32'd1);
            check("done_early", {31'd0, done}, 32'd0);
            check("out_hold", {24'd0, dout}, {24'd0, prev_out});
            tick();
        end
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        check("out", {24'd0, dout}, {24'd0, exp_out});
        check("cnt", {29'd0, cnt}, exp_cnt);
        check("zero", {31'd0, zero}, (v == 0) ? 32'd1 : 32'd0);
        check("unshift", {24'd0, dout >> cnt}, {24'd0, v});
        if (v != 0) check("msb_set", {31'd0, dout[WIDTH-1]}, 32'd1);
        $display("op in=%02h -> out=%02h cnt=%0d zero=%0d", v, dout, cnt, zero);
        tick();
        check("done_drop", {31'd0, done}, 32'd0);
        check("out_stable", {24'd0, dout}, {24'd0, exp_out});
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        rst_n = 1'b0;
        start = 1'b0;
        din   = '0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_out", {24'd0, dout}, 32'd0);
        check("rst_cnt", {29'd0, cnt}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed values with fixed expectations.
        run_op(8'h16);
        check("t1_out", {24'd0, dout}, 32'hB0);
        check("t1_cnt", {29'd0, cnt}, 32'd3);
        run_op(8'h80);
        check("t2a_out", {24'd0, dout}, 32'h80);
        check("t2a_cnt", {29'd0, cnt}, 32'd0);
        run_op(8'h01);
        check("t2b_out", {24'd0, dout}, 32'h80);
        check("t2b_cnt", {29'd0, cnt}, 32'd7);
        run_op(8'h00);
        check("t2c_out", {24'd0, dout}, 32'h00);
        check("t2c_zero", {31'd0, zero}, 32'd1);

        // Start held high: results every 5 cycles, busy starts dropped.
        start = 1'b1;
        din   = 8'h16;
        tick();
        din   = 8'h03;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                check("b2b_busy", {31'd0, busy}, 32'd1);
                check("b2b_nodone", {31'd0, done}, 32'd0);
                tick();
            end
            check("b2b_done", {31'd0, done}, 32'd1);
            check("b2b_out", {24'd0, dout}, (r == 0) ? 32'hB0 : 32'hC0);
            check("b2b_cnt", {29'd0, cnt}, (r == 0) ? 32'd3 : 32'd6);
            $display("b2b result %0d out=%02h cnt=%0d", r, dout, cnt);
            if (r == 1) start = 1'b0;
            tick();
        end
        check("b2b_idle", {31'd0, busy}, 32'd0);
        check("b2b_idle_done", {31'd0, done}, 32'd0);

        // Reset in the cycle after start aborts the operation.
        start = 1'b1;
        din   = 8'h05;
        tick();
        start = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_out", {24'd0, dout}, 32'd0);
        check("abort_cnt", {29'd0, cnt}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        $display("abort after reset: busy=%0d done=%0d", busy, done);

        // Exhaustive sweep.
        for (int x = 0; x < 256; x++) begin
            v = WIDTH'(x);
            run_op(v);
        end

        // Random operands with random idle gaps.
        for (int j = 0; j < 40; j++) begin
            v = WIDTH'($urandom);
            run_op(v);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
